// File: rtl/smc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : smc_pkg
// Purpose  : Shared types and helpers for the sensor/motor/display controller:
//            FSM state and display-view encodings, hex-to-7-segment glyph
//            lookup and 3-bit binary-to-Gray conversion.
// Revision : 1.0  initial release
// ============================================================================
package smc_pkg;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BIN  = 2'd0,
        GRAY = 2'd1,
        EXS3 = 2'd2
    } disp_mode_t;

    // Glyph for "0", shown while the display pipeline is in reset.
    localparam logic [6:0] C_SEG7_ZERO = 7'h3F;

    // Active-high segments ordered {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg7(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    function automatic logic [2:0] bin_to_gray(input logic [2:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Display views rotate BIN -> GRAY -> EXS3 -> BIN.
    function automatic disp_mode_t next_mode(input disp_mode_t mode);
        disp_mode_t nxt;
        case (mode)
            BIN:     nxt = GRAY;
            GRAY:    nxt = EXS3;
            default: nxt = BIN;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sensor_debounce
// Purpose  : Two-flop synchroniser plus stability counter for a raw parallel
//            sensor bus. A value that stays unchanged for DEBOUNCE_CYCLES
//            cycles is accepted as the new level; a one-cycle level_valid
//            accompanies every accepted value that differs from the old one.
//            Pin-to-level latency is 2 + DEBOUNCE_CYCLES cycles.
// Revision : 1.0  initial release
// ============================================================================
module sensor_debounce #(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level,
    output logic             level_valid
);

    localparam int                 C_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);

    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [WIDTH-1:0]   r_cand;
    logic [C_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_level;
    logic               r_valid;

    logic               w_differ;
    logic [C_CNT_W-1:0] w_cnt_next;
    logic               w_accept;

    // The edge on which the candidate first appears already counts as one
    // stable cycle, so a new value is accepted on the edge where the
    // updated count reaches DEBOUNCE_CYCLES.
    always_comb begin
        w_differ   = (r_sync2 != r_cand);
        w_cnt_next = r_cnt;
        if (w_differ) begin
            w_cnt_next = C_CNT_ONE;
        end else if (r_cnt != C_CNT_MAX) begin
            w_cnt_next = r_cnt + C_CNT_ONE;
        end
        w_accept = (w_cnt_next == C_CNT_MAX) && (r_sync2 != r_level);
    end

    // Synchronise the raw pins into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // Track the candidate and how long it has been stable; load it when stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand  <= '0;
            r_cnt   <= '0;
            r_level <= '0;
            r_valid <= 1'b0;
        end else begin
            r_cand  <= r_sync2;
            r_cnt   <= w_cnt_next;
            r_valid <= w_accept;
            if (w_accept) begin
                r_level <= r_sync2;
            end
        end
    end

    assign level       = r_level;
    assign level_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/sensor_motor_controller.sv
`default_nettype none
// ============================================================================
// Module   : sensor_motor_controller
// Purpose  : Debounces the 3-bit level sensor {p,q,r}, runs the motor through
//            a hysteresis FSM with minimum on/off times, and rotates a shared
//            7-segment display through binary, Gray and excess-3 views.
//            Optional build macro FAULT_DETECT_EN adds a sensor-jump fault
//            state; without it fault is tied low.
// Revision : 1.0  initial release
// ============================================================================
module sensor_motor_controller
    import smc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LOW_TH          = 2,
    parameter int HIGH_TH         = 6,
    parameter int MIN_ON_CYCLES   = 64,
    parameter int MIN_OFF_CYCLES  = 64,
    parameter int DISP_PERIOD     = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       p,
    input  logic       q,
    input  logic       r,
    input  logic       en,
    input  logic       disp_next,
    output logic [2:0] level,
    output logic       level_valid,
    output logic       motor,
    output logic [1:0] disp_mode,
    output logic [3:0] disp_code,
    output logic [6:0] seg7,
    output logic       fault
);

    localparam int                  C_ON_W    = $clog2(MIN_ON_CYCLES + 1);
    localparam int                  C_OFF_W   = $clog2(MIN_OFF_CYCLES + 1);
    localparam int                  C_DISP_W  = $clog2(DISP_PERIOD);
    localparam logic [C_ON_W-1:0]   C_ON_MAX  = C_ON_W'(MIN_ON_CYCLES);
    localparam logic [C_OFF_W-1:0]  C_OFF_MAX = C_OFF_W'(MIN_OFF_CYCLES);
    localparam logic [C_DISP_W-1:0] C_DISP_TC = C_DISP_W'(DISP_PERIOD - 1);
    localparam logic [2:0]          C_LOW     = 3'(LOW_TH);
    localparam logic [2:0]          C_HIGH    = 3'(HIGH_TH);

    logic [1:0]          r_rst_sync;
    logic                w_rst_n;
    logic [2:0]          w_level;
    logic                w_level_valid;

    state_t              r_state;
    logic                r_motor;
    logic [C_ON_W-1:0]   r_on_cnt;
    logic [C_OFF_W-1:0]  r_off_cnt;

    disp_mode_t          r_disp_mode;
    logic [C_DISP_W-1:0] r_view_cnt;
    logic [3:0]          w_code;
    logic [3:0]          r_disp_code;
    logic [6:0]          r_seg7;

`ifdef FAULT_DETECT_EN
    logic                r_fault;
    logic [2:0]          r_prev_level;
    logic [2:0]          w_delta;
    logic                w_jump;
`endif

    // Reset asserts immediately and releases two edges after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    sensor_debounce #(
        .WIDTH           (3),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (w_rst_n),
        .raw         ({p, q, r}),
        .level       (w_level),
        .level_valid (w_level_valid)
    );

`ifdef FAULT_DETECT_EN
    // A freshly accepted level more than one step away from the last one.
    always_comb begin
        w_delta = (w_level > r_prev_level) ? (w_level - r_prev_level)
                                           : (r_prev_level - w_level);
        w_jump  = w_level_valid && (w_delta >= 3'd2);
    end

    // Remember the previously accepted level for jump detection.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_prev_level <= 3'd0;
        end else if (w_level_valid) begin
            r_prev_level <= w_level;
        end
    end
`endif

    // Motor FSM with saturating on/off timers; motor mirrors S_RUN.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= S_OFF;
            r_motor   <= 1'b0;
            r_on_cnt  <= '0;
            r_off_cnt <= C_OFF_MAX;
`ifdef FAULT_DETECT_EN
            r_fault   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_OFF: begin
                    if (r_off_cnt != C_OFF_MAX) begin
                        r_off_cnt <= r_off_cnt + 1'b1;
                    end
                    if (en && (w_level <= C_LOW) && (r_off_cnt >= C_OFF_MAX)) begin
                        r_state  <= S_RUN;
                        r_motor  <= 1'b1;
                        r_on_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (r_on_cnt != C_ON_MAX) begin
                        r_on_cnt <= r_on_cnt + 1'b1;
                    end
                    // Disable overrides the minimum on time.
                    if (!en || ((w_level >= C_HIGH) && (r_on_cnt >= C_ON_MAX))) begin
                        r_state   <= S_OFF;
                        r_motor   <= 1'b0;
                        r_off_cnt <= '0;
                    end
                end
`ifdef FAULT_DETECT_EN
                S_FAULT: begin
                    if (!en) begin
                        r_state   <= S_OFF;
                        r_fault   <= 1'b0;
                        r_off_cnt <= '0;
                    end
                end
`endif
                default: begin
                    r_state <= S_OFF;
                    r_motor <= 1'b0;
                end
            endcase
`ifdef FAULT_DETECT_EN
            // A sensor jump wins over any normal transition this cycle.
            if (w_jump && (r_state != S_FAULT)) begin
                r_state <= S_FAULT;
                r_motor <= 1'b0;
                r_fault <= 1'b1;
            end
`endif
        end
    end

    // View timer: advance on terminal count or on request, never twice.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_disp_mode <= BIN;
            r_view_cnt  <= '0;
        end else if (disp_next || (r_view_cnt == C_DISP_TC)) begin
            r_disp_mode <= next_mode(r_disp_mode);
            r_view_cnt  <= '0;
        end else begin
            r_view_cnt  <= r_view_cnt + 1'b1;
        end
    end

    // Value for the current view.
    always_comb begin
        w_code = {1'b0, w_level};
        case (r_disp_mode)
            GRAY:    w_code = {1'b0, bin_to_gray(w_level)};
            EXS3:    w_code = {1'b0, w_level} + 4'd3;
            default: w_code = {1'b0, w_level};
        endcase
    end

    // Register the displayed value and its glyph.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_disp_code <= 4'd0;
            r_seg7      <= C_SEG7_ZERO;
        end else begin
            r_disp_code <= w_code;
            r_seg7      <= hex_to_seg7(w_code);
        end
    end

    assign level       = w_level;
    assign level_valid = w_level_valid;
    assign motor       = r_motor;
    assign disp_mode   = r_disp_mode;
    assign disp_code   = r_disp_code;
    assign seg7        = r_seg7;
`ifdef FAULT_DETECT_EN
    assign fault       = r_fault;
`else
    assign fault       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sensor_motor_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_motor_controller
// Purpose  : Directed self-checking bench for sensor_motor_controller with
//            short debounce/timer/display parameters. Expected debounced
//            levels are queued when pins are driven and compared whenever
//            the DUT pulses level_valid.
// Revision : 1.0  initial release
// ============================================================================
module tb_sensor_motor_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       p, q, r;
    logic       en;
    logic       disp_next;
    logic [2:0] level;
    logic       level_valid;
    logic       motor;
    logic [1:0] disp_mode;
    logic [3:0] disp_code;
    logic [6:0] seg7;
    logic       fault;

    int         total = 0;
    int         bad   = 0;
    logic [2:0] exp_q[$];

`ifdef FAULT_DETECT_EN
    localparam logic EXP_FAULT = 1'b1;
`else
    localparam logic EXP_FAULT = 1'b0;
`endif

    always #5 clk = ~clk;

    sensor_motor_controller #(
        .DEBOUNCE_CYCLES (4),
        .LOW_TH          (2),
        .HIGH_TH         (6),
        .MIN_ON_CYCLES   (8),
        .MIN_OFF_CYCLES  (8),
        .DISP_PERIOD     (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .p           (p),
        .q           (q),
        .r           (r),
        .en          (en),
        .disp_next   (disp_next),
        .level       (level),
        .level_valid (level_valid),
        .motor       (motor),
        .disp_mode   (disp_mode),
        .disp_code   (disp_code),
        .seg7        (seg7),
        .fault       (fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 2 time units past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [2:0] v, input bit expect_update);
        {p, q, r} = v;
        if (expect_update) exp_q.push_back(v);
    endtask

    // Scoreboard: every level_valid pulse must match the oldest queued level.
    always @(posedge clk) begin
        logic [2:0] e;
        #1;
        if (level_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", {31'b0, level_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("level_q", {29'b0, level}, {29'b0, e});
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; disp_next = 1'b0;
        drive(3'd0, 1'b0);
        step(3);

        // Power-on reset values
        check("rst_motor", {31'b0, motor}, 32'd0);
        check("rst_level", {29'b0, level}, 32'd0);
        check("rst_valid", {31'b0, level_valid}, 32'd0);
        check("rst_mode",  {30'b0, disp_mode}, 32'd0);
        check("rst_code",  {28'b0, disp_code}, 32'd0);
        check("rst_seg7",  {25'b0, seg7}, 32'h3F);
        check("rst_fault", {31'b0, fault}, 32'd0);

        rst_n = 1'b1;
        step(4);

        // Bounce 0<->3 every 2 cycles, then hold 3
        for (int i = 0; i < 10; i++) begin
            drive((i % 2 == 0) ? 3'd3 : 3'd0, 1'b0);
            step(2);
        end
        drive(3'd3, 1'b1);
        step(5);
        check("bounce_hold", {29'b0, level}, 32'd0);
        step(1);
        check("bounce_lat6", {29'b0, level}, 32'd3);

        // Hysteresis with minimum on time
        drive(3'd1, 1'b1);
        step(6);
        check("lvl1", {29'b0, level}, 32'd1);
        en = 1'b1;
        step(1);
        check("hyst_on", {31'b0, motor}, 32'd1);
        drive(3'd6, 1'b1);
        step(7);
        check("hyst_min_on_a", {31'b0, motor}, 32'd1);
        step(1);
        check("hyst_min_on_b", {31'b0, motor}, 32'd1);
        step(1);
        check("hyst_off", {31'b0, motor}, 32'd0);
        drive(3'd4, 1'b1);
        step(6);
        check("mid_off_a", {31'b0, motor}, 32'd0);
        step(12);
        check("mid_off_b", {31'b0, motor}, 32'd0);
        drive(3'd1, 1'b1);
        step(6);
        check("restart_wait", {31'b0, motor}, 32'd0);
        step(1);
        check("restart", {31'b0, motor}, 32'd1);

        // en low drops the motor next edge; restart waits out minimum off time
        en = 1'b0;
        step(1);
        check("en_off", {31'b0, motor}, 32'd0);
        en = 1'b1;
        step(8);
        check("min_off_hold", {31'b0, motor}, 32'd0);
        step(1);
        check("min_off_done", {31'b0, motor}, 32'd1);

        // Mid-operation reset takes effect within the same cycle
        rst_n = 1'b0;
        #1;
        check("mrst_motor", {31'b0, motor}, 32'd0);
        check("mrst_level", {29'b0, level}, 32'd0);
        check("mrst_mode",  {30'b0, disp_mode}, 32'd0);
        check("mrst_code",  {28'b0, disp_code}, 32'd0);
        check("mrst_seg7",  {25'b0, seg7}, 32'h3F);
        en = 1'b0;
        drive(3'd6, 1'b0);
        step(2);

        // Display rotation with level 6
        rst_n = 1'b1;
        exp_q.push_back(3'd6);
        step(10);
        check("disp_bin_mode", {30'b0, disp_mode}, 32'd0);
        check("disp_bin_code", {28'b0, disp_code}, 32'd6);
        check("disp_bin_seg",  {25'b0, seg7}, 32'h7D);
        step(3);
        check("disp_gray_mode", {30'b0, disp_mode}, 32'd1);
        check("disp_gray_code", {28'b0, disp_code}, 32'd5);
        check("disp_gray_seg",  {25'b0, seg7}, 32'h6D);
        disp_next = 1'b1;
        step(1);
        disp_next = 1'b0;
        step(1);
        check("disp_exs3_mode", {30'b0, disp_mode}, 32'd2);
        check("disp_exs3_code", {28'b0, disp_code}, 32'd9);
        check("disp_exs3_seg",  {25'b0, seg7}, 32'h6F);

        // disp_next on the terminal-count edge advances exactly once
        step(8);
        disp_next = 1'b1;
        step(1);
        disp_next = 1'b0;
        check("tc_single_mode", {30'b0, disp_mode}, 32'd0);
        step(1);
        check("tc_single_code", {28'b0, disp_code}, 32'd6);
        step(8);
        check("tc_restart_hold", {30'b0, disp_mode}, 32'd0);
        step(1);
        check("tc_restart_adv", {30'b0, disp_mode}, 32'd1);

        // Ramp down in single steps, then jump 1 -> 7
        en = 1'b1;
        for (int v = 5; v >= 1; v--) begin
            drive(3'(v), 1'b1);
            step(6);
        end
        check("pre_jump_run", {31'b0, motor}, 32'd1);
        drive(3'd7, 1'b1);
        step(7);
        check("jump_motor", {31'b0, motor}, 32'd0);
        check("jump_fault", {31'b0, fault}, {31'b0, EXP_FAULT});
        en = 1'b0;
        step(1);
        check("fault_clear", {31'b0, fault}, 32'd0);
        en = 1'b1;
        step(2);
        check("post_fault_motor", {31'b0, motor}, 32'd0);

        step(8);
        check("queue_drain", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
